wb_regfile: RTL and testbench

// Writeback stage plus integer register file; consumes the MEM/WB pipeline register outputs.

---
 rtl/wb_regfile.sv | 95 +++++++++
 tb/tb_wb_regfile.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Writeback result select/load extend plus 32x32 register file with write-through read ports.
// resultW and reads are combinational; writes and commit count update at posedge; no backpressure.
module wb_regfile #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             regwriteW,
  input  logic [4:0]       rdW,
  input  logic [2:0]       resultsrcW,
  input  logic [2:0]       loadsrcW,
  input  logic [XLEN-1:0]  aluresultW,
  input  logic [XLEN-1:0]  readDataW,
  input  logic [XLEN-1:0]  auipcW,
  input  logic [XLEN-1:0]  immextW,
  input  logic [XLEN-1:0]  pcplus4W,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  output logic [XLEN-1:0]  rd1D,
  output logic [XLEN-1:0]  rd2D,
  output logic [XLEN-1:0]  resultW,
  output logic [CNT_W-1:0] commit_cnt
);

  logic [7:0]      load_byte;
  logic [15:0]     load_half;
  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] regs [NREG];
  logic            do_write;

  // Misaligned halfwords simply use the lane picked by bit 1.
  always_comb begin
    load_half = aluresultW[1] ? readDataW[31:16] : readDataW[15:0];
    case (aluresultW[1:0])
      2'd0:    load_byte = readDataW[7:0];
      2'd1:    load_byte = readDataW[15:8];
      2'd2:    load_byte = readDataW[23:16];
      default: load_byte = readDataW[31:24];
    endcase
  end

  always_comb begin
    case (loadsrcW)
      3'b001:  load_val = {{24{load_byte[7]}}, load_byte};
      3'b010:  load_val = {{16{load_half[15]}}, load_half};
      3'b011:  load_val = {24'h0, load_byte};
      3'b100:  load_val = {16'h0, load_half};
      default: load_val = readDataW;
    endcase
  end

  always_comb begin
    case (resultsrcW)
      3'b001:  resultW = load_val;
      3'b010:  resultW = pcplus4W;
      3'b011:  resultW = immextW;
      3'b100:  resultW = auipcW;
      default: resultW = aluresultW;
    endcase
  end

  assign do_write = regwriteW && (rdW != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      commit_cnt <= '0;
    end else if (do_write) begin
      regs[rdW]  <= resultW;
      commit_cnt <= commit_cnt + CNT_W'(1);
    end
  end

  // Same-cycle write-through so decode sees the value being committed this cycle.
  always_comb begin
    if (rst || rs1D == 5'd0)
      rd1D = '0;
    else if (do_write && rdW == rs1D)
      rd1D = resultW;
    else
      rd1D = regs[rs1D];

    if (rst || rs2D == 5'd0)
      rd2D = '0;
    else if (do_write && rdW == rs2D)
      rd2D = resultW;
    else
      rd2D = regs[rs2D];
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile; expectations queued by stimulus, checked by a negedge monitor.
module tb_wb_regfile;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          regwriteW;
  logic [4:0]    rdW;
  logic [2:0]    resultsrcW;
  logic [2:0]    loadsrcW;
  logic [31:0]   aluresultW;
  logic [31:0]   readDataW;
  logic [31:0]   auipcW;
  logic [31:0]   immextW;
  logic [31:0]   pcplus4W;
  logic [4:0]    rs1D;
  logic [4:0]    rs2D;
  logic [31:0]   rd1D;
  logic [31:0]   rd2D;
  logic [31:0]   resultW;
  logic [CW-1:0] commit_cnt;

  wb_regfile #(.XLEN(32), .NREG(32), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .regwriteW  (regwriteW),
    .rdW        (rdW),
    .resultsrcW (resultsrcW),
    .loadsrcW   (loadsrcW),
    .aluresultW (aluresultW),
    .readDataW  (readDataW),
    .auipcW     (auipcW),
    .immextW    (immextW),
    .pcplus4W   (pcplus4W),
    .rs1D       (rs1D),
    .rs2D       (rs2D),
    .rd1D       (rd1D),
    .rd2D       (rd2D),
    .resultW    (resultW),
    .commit_cnt (commit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]   rd1;
    logic [31:0]   rd2;
    logic [31:0]   res;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t  exp_q [$];
  string name_q [$];
  int    checks = 0;
  int    errors = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks += 4;
      if (rd1D !== e.rd1) begin
        errors++;
        $display("FAIL %s rd1D got %h exp %h", n, rd1D, e.rd1);
      end
      if (rd2D !== e.rd2) begin
        errors++;
        $display("FAIL %s rd2D got %h exp %h", n, rd2D, e.rd2);
      end
      if (resultW !== e.res) begin
        errors++;
        $display("FAIL %s resultW got %h exp %h", n, resultW, e.res);
      end
      if (commit_cnt !== e.cnt) begin
        errors++;
        $display("FAIL %s commit_cnt got %0d exp %0d", n, commit_cnt, e.cnt);
      end
    end
  end

  // Apply one cycle of inputs, queue the expected outputs before the edge, then advance.
  task automatic cyc(input logic we, input logic [4:0] rd, input logic [2:0] rs,
                     input logic [2:0] ls, input logic [31:0] alu,
                     input logic [4:0] a1, input logic [4:0] a2, input string nm,
                     input logic [31:0] e1, input logic [31:0] e2,
                     input logic [31:0] er, input logic [CW-1:0] ec);
    exp_t e;
    regwriteW  = we;
    rdW        = rd;
    resultsrcW = rs;
    loadsrcW   = ls;
    aluresultW = alu;
    rs1D       = a1;
    rs2D       = a2;
    e.rd1 = e1;
    e.rd2 = e2;
    e.res = er;
    e.cnt = ec;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] RD = 32'h80F17F01;

  initial begin
    rst        = 1'b1;
    readDataW  = RD;
    auipcW     = 32'h0000_2000;
    immextW    = 32'h1234_5000;
    pcplus4W   = 32'h0000_0104;
    regwriteW  = 1'b1;
    rdW        = 5'd3;
    resultsrcW = 3'b000;
    loadsrcW   = 3'b000;
    aluresultW = 32'h55;
    rs1D       = 5'd3;
    rs2D       = 5'd3;
    @(posedge clk);
    #1;
    cyc(1'b1, 5'd3, 3'b000, 3'b000, 32'h55, 5'd3, 5'd3, "reset_hold", 0, 0, 32'h55, 0);
    rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      cyc(1'b0, 5'd0, 3'b000, 3'b000, 32'h0, 5'(i), 5'(31 - i), "reset_read", 0, 0, 0, 0);
    end

    cyc(1'b1, 5'd5, 3'b000, 3'b000, 32'hDEADBEEF, 5'd5, 5'd0, "alu_bypass",
        32'hDEADBEEF, 0, 32'hDEADBEEF, 0);
    cyc(1'b0, 5'd0, 3'b000, 3'b000, 32'h0, 5'd5, 5'd5, "alu_stored",
        32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 1);

    cyc(1'b1, 5'd7, 3'b001, 3'b001, 32'h1000, 5'd7, 5'd5, "lb_off0",
        32'h00000001, 32'hDEADBEEF, 32'h00000001, 1);
    cyc(1'b1, 5'd7, 3'b001, 3'b001, 32'h1003, 5'd7, 5'd5, "lb_off3",
        32'hFFFFFF80, 32'hDEADBEEF, 32'hFFFFFF80, 2);
    cyc(1'b1, 5'd7, 3'b001, 3'b011, 32'h1002, 5'd7, 5'd5, "lbu_off2",
        32'h000000F1, 32'hDEADBEEF, 32'h000000F1, 3);
    cyc(1'b1, 5'd7, 3'b001, 3'b010, 32'h1002, 5'd7, 5'd5, "lh_off2",
        32'hFFFF80F1, 32'hDEADBEEF, 32'hFFFF80F1, 4);
    cyc(1'b1, 5'd7, 3'b001, 3'b100, 32'h1000, 5'd7, 5'd5, "lhu_off0",
        32'h00007F01, 32'hDEADBEEF, 32'h00007F01, 5);
    cyc(1'b1, 5'd7, 3'b001, 3'b010, 32'h1001, 5'd7, 5'd5, "lh_off1",
        32'h00007F01, 32'hDEADBEEF, 32'h00007F01, 6);
    cyc(1'b1, 5'd7, 3'b001, 3'b000, 32'h1000, 5'd7, 5'd5, "lw", RD, 32'hDEADBEEF, RD, 7);
    cyc(1'b1, 5'd7, 3'b001, 3'b111, 32'h1002, 5'd7, 5'd5, "load_111_lw", RD, 32'hDEADBEEF, RD, 8);
    cyc(1'b0, 5'd0, 3'b000, 3'b000, 32'h0, 5'd7, 5'd7, "x7_stored", RD, RD, 32'h0, 9);

    cyc(1'b1, 5'd8, 3'b010, 3'b000, 32'h0, 5'd8, 5'd7, "src_pcplus4",
        32'h104, RD, 32'h104, 9);
    cyc(1'b1, 5'd8, 3'b011, 3'b000, 32'h0, 5'd8, 5'd7, "src_immext",
        32'h12345000, RD, 32'h12345000, 10);
    cyc(1'b1, 5'd8, 3'b100, 3'b000, 32'h0, 5'd8, 5'd7, "src_auipc",
        32'h2000, RD, 32'h2000, 11);
    cyc(1'b1, 5'd8, 3'b111, 3'b000, 32'hA5A50001, 5'd8, 5'd7, "src_111_alu",
        32'hA5A50001, RD, 32'hA5A50001, 12);
    cyc(1'b1, 5'd9, 3'b000, 3'b000, 32'h13579BDF, 5'd9, 5'd9, "dual_bypass",
        32'h13579BDF, 32'h13579BDF, 32'h13579BDF, 13);

    cyc(1'b1, 5'd0, 3'b000, 3'b000, 32'hFFFFFFFF, 5'd0, 5'd9, "x0_write",
        0, 32'h13579BDF, 32'hFFFFFFFF, 14);
    cyc(1'b0, 5'd0, 3'b000, 3'b000, 32'h0, 5'd8, 5'd0, "x0_no_count",
        32'hA5A50001, 0, 32'h0, 14);

    cyc(1'b1, 5'd3, 3'b000, 3'b000, 32'h33, 5'd4, 5'd3, "x3_write", 0, 32'h33, 32'h33, 14);
    cyc(1'b0, 5'd0, 3'b000, 3'b000, 32'h0, 5'd3, 5'd9, "x3_stored",
        32'h33, 32'h13579BDF, 32'h0, 15);

    rst = 1'b1;
    cyc(1'b1, 5'd3, 3'b000, 3'b000, 32'h77, 5'd3, 5'd5, "rst_midop", 0, 0, 32'h77, 15);
    rst = 1'b0;
    cyc(1'b0, 5'd0, 3'b000, 3'b000, 32'h0, 5'd3, 5'd5, "post_rst", 0, 0, 32'h0, 0);

    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 5'(i + 1), 3'b000, 3'b000, 32'h111 * i, 5'(i + 1), 5'd0, "wrap_fill",
          32'h111 * i, 0, 32'h111 * i, CW'(i));
    end
    cyc(1'b0, 5'd0, 3'b000, 3'b000, 32'h0, 5'd16, 5'd2, "wrap_zero",
        32'h111 * 15, 32'h111, 32'h0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain queue left %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
